// File: rtl/image_pad_loader_pkg.sv
// Shared dimensions and loader state encoding for the image pad loader and
// the convolution layers that consume its padded frame.
package image_pad_loader_pkg;

    localparam int IMG_DIM    = 28;
    localparam int PAD        = 2;
    localparam int PADDED_DIM = 32;
    localparam int CNT_W      = 5;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/image_pad_loader_raster_counter.sv
// Row/column raster counter for the 28x28 interior: wraps at the frame edge,
// resyncs to (0,0) on start-of-frame and flags the last pixel of a frame.
module raster_counter
    import image_pad_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             sof,
    output logic [CNT_W-1:0] wr_row,
    output logic [CNT_W-1:0] wr_col,
    output logic             last_pix
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_DIM - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    // A start-of-frame pixel always lands at (0,0), so the next position is
    // derived from the write address rather than the stored counters.
    always_comb begin
        wr_row   = sof ? '0 : row_q;
        wr_col   = sof ? '0 : col_q;
        last_pix = advance && (wr_row == LAST_IDX) && (wr_col == LAST_IDX);
        row_d    = row_q;
        col_d    = col_q;
        if (advance) begin
            if (wr_col == LAST_IDX) begin
                col_d = '0;
                row_d = (wr_row == LAST_IDX) ? '0 : wr_row + 1'b1;
            end else begin
                col_d = wr_col + 1'b1;
                row_d = wr_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/image_pad_loader.sv
// Streams a 28x28 raster of signed pixels into a zero-padded 32x32 frame
// buffer and holds it stable until the consumer acknowledges it.
module image_pad_loader
    import image_pad_loader_pkg::*;
#(
    parameter int bitwidth = 16
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic signed [bitwidth-1:0]                              pix_in,
    input  logic                                                    pix_valid,
    input  logic                                                    pix_sof,
    output logic                                                    pix_ready,
    output logic signed [PADDED_DIM-1:0][PADDED_DIM-1:0][bitwidth-1:0] image_padded,
    output logic                                                    frame_valid,
    input  logic                                                    frame_ack
);

    // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
    // pix_ready is high exactly while in LOAD and never depends on any input.

    state_e state_q, state_d;

    logic [CNT_W-1:0] wr_row;
    logic [CNT_W-1:0] wr_col;
    logic             last_pix;
    logic             accept;

    logic signed [bitwidth-1:0] interior_q [IMG_DIM][IMG_DIM];
    logic signed [bitwidth-1:0] interior_d [IMG_DIM][IMG_DIM];

    assign pix_ready   = (state_q == LOAD);
    assign frame_valid = (state_q == FULL);
    assign accept      = pix_valid && pix_ready;

    raster_counter u_raster_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (accept),
        .sof      (pix_sof),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (last_pix)  state_d = FULL;
            FULL:    if (frame_ack) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        interior_d = interior_q;
        if (accept) begin
            interior_d[wr_row][wr_col] = pix_in;
        end
    end

    // The border is tied to zero here; only the interior is stored.
    always_comb begin
        image_padded = '0;
        for (int r = 0; r < IMG_DIM; r++) begin
            for (int c = 0; c < IMG_DIM; c++) begin
                image_padded[r + PAD][c + PAD] = interior_q[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IMG_DIM; r++) begin
                for (int c = 0; c < IMG_DIM; c++) begin
                    interior_q[r][c] <= '0;
                end
            end
        end else begin
            interior_q <= interior_d;
        end
    end

endmodule

// File: tb/tb_image_pad_loader.sv
// Directed bench for image_pad_loader: a raster model predicts every write,
// a queue of expected writes is checked after each edge, frames are compared whole.
module tb_image_pad_loader;

    localparam int W = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [W-1:0]              pix_in = '0;
    logic                             pix_valid = 1'b0;
    logic                             pix_sof = 1'b0;
    logic                             pix_ready;
    logic signed [31:0][31:0][W-1:0]  image_padded;
    logic                             frame_valid;
    logic                             frame_ack = 1'b0;

    image_pad_loader #(.bitwidth(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_sof      (pix_sof),
        .pix_ready    (pix_ready),
        .image_padded (image_padded),
        .frame_valid  (frame_valid),
        .frame_ack    (frame_ack)
    );

    // scoreboard / reference model
    logic [25:0]  exp_q[$];
    logic [W-1:0] m_img [28][28];
    int           m_row, m_col;
    logic         m_full;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                m_img[r][c] = '0;
        m_row  = 0;
        m_col  = 0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_frame(input string tag);
        logic [W-1:0] e;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                e = (r >= 2 && r < 30 && c >= 2 && c < 30) ? m_img[r-2][c-2] : '0;
                chk($sformatf("%s[%0d][%0d]", tag, r, c), 32'(image_padded[r][c]), 32'(e));
            end
        end
    endtask

    // driver: called on a falling edge, returns on the next falling edge
    task automatic send_pix(input logic [W-1:0] v, input logic sof);
        int r, c;
        logic [25:0] item;
        pix_in    = v;
        pix_valid = 1'b1;
        pix_sof   = sof;
        chk("pix_ready", 32'(pix_ready), 32'(!m_full));
        if (!m_full) begin
            r = sof ? 0 : m_row;
            c = sof ? 0 : m_col;
            m_img[r][c] = v;
            exp_q.push_back({5'(r), 5'(c), v});
            if (r == 27 && c == 27) m_full = 1'b1;
            m_col = (c == 27) ? 0 : c + 1;
            m_row = (c == 27) ? ((r == 27) ? 0 : r + 1) : r;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        while (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            chk("pixel_write", 32'(image_padded[item[25:21] + 2][item[20:16] + 2]), 32'(item[15:0]));
        end
        chk("frame_valid", 32'(frame_valid), 32'(m_full));
        @(negedge clk);
    endtask

    task automatic send_seq(input int n);
        for (int i = 0; i < n; i++) send_pix(W'(m_row * 28 + m_col), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b0;
            pix_sof   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            pix_sof = 1'b0;
            chk("idle_frame_valid", 32'(frame_valid), 32'(m_full));
            @(negedge clk);
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        m_full = 1'b0;
        chk("ack_pix_ready", 32'(pix_ready), 32'd1);
        chk("ack_frame_valid", 32'(frame_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_frame("rst_img");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // plain back-to-back frame
        send_seq(784);
        chk("f1_full", 32'(frame_valid), 32'd1);
        chk("f1_ready", 32'(pix_ready), 32'd0);
        chk("f1_22", 32'(image_padded[2][2]), 32'd0);
        chk("f1_2929", 32'(image_padded[29][29]), 32'd783);
        chk("f1_229", 32'(image_padded[2][29]), 32'd27);
        chk("f1_292", 32'(image_padded[29][2]), 32'd756);
        check_frame("f1");

        // pixels offered while FULL are ignored
        for (int i = 0; i < 10; i++) send_pix(16'h7FFF, 1'b0);
        check_frame("full_hold");
        ack();

        // same frame with random gaps and stray sof without valid
        for (int i = 0; i < 784; i++) begin
            idle($urandom_range(0, 3));
            send_pix(W'(m_row * 28 + m_col), 1'b0);
        end
        check_frame("gaps");
        ack();

        // resync on sof mid-frame
        send_seq(100);
        send_pix(16'hFFFB, 1'b1);
        send_seq(783);
        chk("sof_full", 32'(frame_valid), 32'd1);
        chk("sof_22", 32'(image_padded[2][2]), 32'h0000FFFB);
        check_frame("sof");
        ack();

        // reset mid-frame, then an all-ones frame with a stray ack in LOAD
        send_seq(300);
        do_reset();
        for (int i = 0; i < 400; i++) send_pix(16'd1, 1'b0);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        chk("load_ack_ready", 32'(pix_ready), 32'd1);
        chk("load_ack_fv", 32'(frame_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 384; i++) send_pix(16'd1, 1'b0);
        chk("ones_full", 32'(frame_valid), 32'd1);
        chk("ones_2929", 32'(image_padded[29][29]), 32'd1);
        check_frame("ones");
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
